// File: rtl/seg_pkg.sv
// Shared types and segment codes for the seven-segment display path.
// Codes are active-low {dp,g,f,e,d,c,b,a}; dp is always off.
package seg_pkg;

    typedef logic [7:0] seg_t;
    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    localparam seg_t SEG_0     = 8'hC0;
    localparam seg_t SEG_1     = 8'hF9;
    localparam seg_t SEG_2     = 8'hA4;
    localparam seg_t SEG_3     = 8'hB0;
    localparam seg_t SEG_4     = 8'h99;
    localparam seg_t SEG_5     = 8'h92;
    localparam seg_t SEG_6     = 8'h82;
    localparam seg_t SEG_7     = 8'hF8;
    localparam seg_t SEG_8     = 8'h80;
    localparam seg_t SEG_9     = 8'h90;
    localparam seg_t SEG_DASH  = 8'hBF;
    localparam seg_t SEG_E     = 8'h86;
    localparam seg_t SEG_BLANK = 8'hFF;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to seven-segment decoder. Non-decimal values show a dash so
// corrupted timer digits are visible instead of silently wrong.
import seg_pkg::*;

module bcd_to_seg (
    input  logic [3:0] value,
    input  logic       blank,
    output seg_t       seg
);

    // Decode the digit, forcing all segments off when blanked
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (value)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/time_seg_display.sv
// Scans the timer's hundreds/tens/ones digits plus a game-over status digit
// onto a 4-digit common-anode display. Inputs are captured once per frame so
// a digit set is never shown half-updated.
import seg_pkg::*;

module time_seg_display #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int DEAD_CYC = 50,
    parameter int BLINK_HZ = 2,
    parameter int LZB      = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] time_1s,
    input  logic [3:0] time_10s,
    input  logic [3:0] time_100s,
    input  logic       time_max_flag,
    input  logic       game_over,
    output logic [3:0] sel,
    output logic [7:0] seg
);

    localparam int SLOT_CYC   = CLK_FREQ / SCAN_HZ;
    localparam int BLINK_HALF = CLK_FREQ / (2 * BLINK_HZ);
    localparam int SLOT_W     = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYC - 1);
    localparam logic [SLOT_W-1:0]  DEAD_START = SLOT_W'(SLOT_CYC - DEAD_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [SLOT_W-1:0]  slot_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    digit_idx_t         idx;
    scan_state_t        state;
    logic               blink_on;

    logic [3:0] snap_1s, snap_10s, snap_100s;
    logic       snap_max, snap_go;

    logic       slot_wrap, snap_take;
    logic [3:0] digit_val;
    logic       digit_blank;
    seg_t       digit_seg, slot_seg;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign snap_take = slot_wrap && (idx == 2'd3);

    // Slot counter, digit index and SHOW/BLANK phase; state tracks slot_cnt
    // so SHOW holds exactly while the counter is below DEAD_START
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            slot_cnt <= '0;
            idx      <= '0;
            state    <= SHOW;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            idx      <= idx + 2'd1;
            state    <= SHOW;
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
            if (slot_cnt + SLOT_W'(1) == DEAD_START)
                state <= BLANK;
        end
    end

    // Capture all display inputs together at the start of each frame
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            snap_1s   <= '0;
            snap_10s  <= '0;
            snap_100s <= '0;
            snap_max  <= 1'b0;
            snap_go   <= 1'b0;
        end else if (snap_take) begin
            snap_1s   <= time_1s;
            snap_10s  <= time_10s;
            snap_100s <= time_100s;
            snap_max  <= time_max_flag;
            snap_go   <= game_over;
        end
    end

    // Blink phase runs only while saturated; a frame without the flag
    // restarts it in the visible phase on the same edge as the snapshot
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (snap_take && !time_max_flag) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (snap_max) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Select the current slot's digit and its blanking (blink, leading zeros)
    always_comb begin
        digit_val   = 4'd0;
        digit_blank = 1'b1;
        case (idx)
            2'd0: begin
                digit_val   = snap_1s;
                digit_blank = !blink_on;
            end
            2'd1: begin
                digit_val   = snap_10s;
                digit_blank = !blink_on ||
                              ((LZB != 0) && (snap_100s == 4'd0) && (snap_10s == 4'd0));
            end
            2'd2: begin
                digit_val   = snap_100s;
                digit_blank = !blink_on || ((LZB != 0) && (snap_100s == 4'd0));
            end
            default: begin
                digit_val   = 4'd0;
                digit_blank = 1'b1;
            end
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .value (digit_val),
        .blank (digit_blank),
        .seg   (digit_seg)
    );

    assign slot_seg = (idx == 2'd3) ? (snap_go ? SEG_E : SEG_BLANK) : digit_seg;

    // Register the anode/segment drive; reset blanks the display at once
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sel <= 4'b1111;
            seg <= SEG_BLANK;
        end else if (state == SHOW) begin
            sel <= ~(4'b0001 << idx);
            seg <= slot_seg;
        end else begin
            sel <= 4'b1111;
            seg <= SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_time_seg_display.sv
// Self-checking bench for time_seg_display: a frame/slot arithmetic model
// predicts sel/seg on every clock.
module tb_time_seg_display;

    localparam int CLK_FREQ = 1000;
    localparam int SCAN_HZ  = 100;
    localparam int DEAD_CYC = 2;
    localparam int BLINK_HZ = 10;
    localparam int LZB      = 1;

    localparam int SLOT     = CLK_FREQ / SCAN_HZ;          // 10
    localparam int SHOW_CYC = SLOT - DEAD_CYC;             // 8
    localparam int FRAME    = 4 * SLOT;                    // 40
    localparam int HALF     = CLK_FREQ / (2 * BLINK_HZ);   // 50

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [3:0] time_1s = 4'd0;
    logic [3:0] time_10s = 4'd0;
    logic [3:0] time_100s = 4'd0;
    logic       time_max_flag = 1'b0;
    logic       game_over = 1'b0;
    logic [3:0] sel;
    logic [7:0] seg;

    int    n_vec = 0;
    int    n_bad = 0;
    int    t;
    string phase = "reset";

    // model of the frame snapshot
    int m1, m10, m100, mstart;
    bit mmax, mgo;

    time_seg_display #(
        .CLK_FREQ (CLK_FREQ),
        .SCAN_HZ  (SCAN_HZ),
        .DEAD_CYC (DEAD_CYC),
        .BLINK_HZ (BLINK_HZ),
        .LZB      (LZB)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .time_1s       (time_1s),
        .time_10s      (time_10s),
        .time_100s     (time_100s),
        .time_max_flag (time_max_flag),
        .game_over     (game_over),
        .sel           (sel),
        .seg           (seg)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d: got %h, want %h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_code(input int v);
        case (v)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    task automatic model_reset();
        t = 0;
        m1 = 0; m10 = 0; m100 = 0;
        mmax = 1'b0; mgo = 1'b0; mstart = 0;
    endtask

    // one clock: predict the output for cycle p = t-1, compare, then take
    // the frame snapshot if this edge starts a new frame
    task automatic step();
        int p, cnt, idx;
        bit vis;
        logic [3:0] es;
        logic [7:0] eg;
        @(posedge sys_clk);
        t++;
        p   = t - 1;
        cnt = p % SLOT;
        idx = (p / SLOT) % 4;
        vis = !mmax || (((p - mstart) / HALF) % 2 == 0);
        if (cnt >= SHOW_CYC) begin
            es = 4'b1111;
            eg = 8'hFF;
        end else begin
            es = ~(4'b0001 << idx);
            case (idx)
                0:       eg = vis ? ref_code(m1) : 8'hFF;
                1:       eg = (!vis || (m100 == 0 && m10 == 0)) ? 8'hFF : ref_code(m10);
                2:       eg = (!vis || m100 == 0) ? 8'hFF : ref_code(m100);
                default: eg = mgo ? 8'h86 : 8'hFF;
            endcase
        end
        #1;
        check_eq({phase, ".sel"}, {4'h0, sel}, {4'h0, es});
        check_eq({phase, ".seg"}, seg, eg);
        if (t % FRAME == 0) begin
            if (time_max_flag && !mmax) mstart = t;
            mmax = time_max_flag;
            mgo  = game_over;
            m1   = int'(time_1s);
            m10  = int'(time_10s);
            m100 = int'(time_100s);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_time(input int h, input int te, input int o);
        time_100s = 4'(h);
        time_10s  = 4'(te);
        time_1s   = 4'(o);
    endtask

    initial begin
        model_reset();
        sys_rst = 1'b1;
        repeat (3) begin
            @(posedge sys_clk);
            #1;
            check_eq("rst.sel", {4'h0, sel}, 8'h0F);
            check_eq("rst.seg", seg, 8'hFF);
        end
        #2 sys_rst = 1'b0;

        phase = "d742";
        set_time(2, 4, 7);
        run(2 * FRAME);

        phase = "zeros";
        set_time(0, 0, 0);
        run(2 * FRAME);

        phase = "lz503";
        set_time(3, 0, 5);
        run(2 * FRAME);

        phase = "tensA";
        time_10s = 4'hA;
        run(FRAME);
        phase = "midframe";
        repeat (2 * FRAME) begin
            time_1s = 4'($urandom_range(0, 9));
            step();
        end

        phase = "blink";
        set_time(9, 9, 9);
        time_max_flag = 1'b1;
        run(6 * FRAME);
        time_max_flag = 1'b0;
        run(2 * FRAME);

        phase = "gameover";
        game_over = 1'b1;
        run(2 * FRAME);
        game_over = 1'b0;

        phase = "random";
        repeat (800) begin
            if ($urandom_range(0, 15) == 0) begin
                time_1s       = 4'($urandom_range(0, 15));
                time_10s      = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                time_100s     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                time_max_flag = ($urandom_range(0, 3) == 0);
                game_over     = ($urandom_range(0, 1) == 0);
            end
            step();
        end

        // asynchronous reset in the middle of a SHOW slot
        phase = "async";
        time_max_flag = 1'b0;
        while (t % SLOT != 3) step();
        #2 sys_rst = 1'b1;
        #1;
        check_eq("arst.sel", {4'h0, sel}, 8'h0F);
        check_eq("arst.seg", seg, 8'hFF);
        repeat (2) begin
            @(posedge sys_clk);
            #1;
            check_eq("arst.hold.sel", {4'h0, sel}, 8'h0F);
            check_eq("arst.hold.seg", seg, 8'hFF);
        end
        #2 sys_rst = 1'b0;
        model_reset();
        phase = "restart";
        set_time(1, 2, 3);
        game_over = 1'b1;
        run(3 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
